// File: rtl/seg7_scan_display.sv
// Two-digit multiplexed 7-segment driver fed by an AXI-Stream slave port.
// Accepted values are held on the display for a minimum interval before
// the next one may be taken; the digit scan runs continuously and is never
// disturbed by traffic on the stream.
module seg7_scan_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int HOLD_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [1:0][6:0] s_data,
  output logic [6:0]      seg,
  output logic [1:0]      an,
  output logic [7:0]      accept_count
);

  // Counter widths; a divide or hold of 1 still needs one bit of storage.
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD    = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BLANK, // nothing received since reset
    ST_SHOW,  // hold interval running, input ignored
    ST_READY  // hold expired, still displaying, awaiting data
  } state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic [RW-1:0]   refresh_cnt;
  logic            sel;
  logic [1:0][6:0] display;
  logic            accept;

  // Ready depends only on the registered state, never on s_valid.
  assign s_ready = (state != ST_SHOW);
  assign accept  = s_valid && s_ready;

  // Handshake FSM: latches data, runs the hold interval, counts accepts.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_BLANK;
      hold_cnt     <= '0;
      // NOTE: the display register is explicitly reset so the held value
      // is discarded on reset rather than reappearing once blanking ends.
      display      <= '0;
      accept_count <= 8'd0;
    end else begin
      case (state)
        ST_BLANK, ST_READY: begin
          if (accept) begin
            state        <= ST_SHOW;
            hold_cnt     <= HOLD_LOAD;
            display      <= s_data;
            accept_count <= accept_count + 8'd1;
          end
        end
        ST_SHOW: begin
          if (hold_cnt == '0) begin
            state <= ST_READY;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: begin
          state <= ST_BLANK;
        end
      endcase
    end
  end

  // Free-running scan divider; toggles the digit select at terminal count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      refresh_cnt <= '0;
      sel         <= 1'b0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      sel         <= ~sel;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Anode/segment decode from registered state only (active-low outputs).
  // NOTE: defaults first so every path assigns both outputs and no latch
  // is inferred.
  always_comb begin
    an  = 2'b11;
    seg = 7'h7F;
    if (state != ST_BLANK) begin
      if (!sel) begin
        an  = 2'b10;
        seg = ~display[0];
      end else begin
        an  = 2'b01;
        seg = ~display[1];
      end
    end
  end

endmodule
